rook_move_scanner: RTL and testbench
====================================

Name: rook_move_scanner

Overview:
- Sequential move generator that sits directly downstream of the 64x5 board RAM and consumes its read port.
- On start, it reads the source square, then walks the four orthogonal rays one RAM read at a time.
- Each pseudo-legal rook destination is emitted on a valid/ready stream to the downstream move checker.
- Serves rooks, and the orthogonal half of queen moves.

Parameters:
- RD_LAT, 1, board RAM read latency in cycles (supported values 1 or 2).
- SQ_W, 6, square index width; index = rank*8 + file, a1=0, h1=7, a8=56, h8=63.
- PC_W, 5, piece code width; 0 = empty, 1..16 = white, 17..31 = black.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a scan; ignored while busy=1.
- src_sq  in  SQ_W  source square; sampled when start is accepted.
- side  in  1  mover colour (0 white, 1 black); sampled with start.
- busy  out  1  high from the cycle after start is accepted until done.
- ram_en  out  1  read enable to board RAM.
- ram_addr  out  SQ_W  read address.
- ram_rdata  in  PC_W  piece code, valid RD_LAT cycles after ram_en.
- mv_valid  out  1  destination available.
- mv_ready  in  1  downstream accepts; a transfer occurs when mv_valid && mv_ready.
- mv_dst  out  SQ_W  destination square.
- mv_capture  out  1  destination holds an enemy piece.
- done  out  1  one-cycle pulse at scan end.
- err  out  1  one-cycle pulse coincident with done when the source square is empty or holds an enemy piece.
- move_count  out  4  moves transferred in the last scan (0..14); held until the next start.

Behaviour:
- Reset: state=IDLE.
  - busy, ram_en, mv_valid, done, err, mv_capture = 0.
  - ram_addr, mv_dst, move_count = 0.
- FSM states: IDLE, SRC_RD, SRC_WT, STEP, RD, WT, CHK, EMIT, NXT_DIR, FIN.
- IDLE: when start=1, latch src_sq and side, then go to SRC_RD.
- SRC_RD: assert ram_en for one cycle with ram_addr=src.
  - Then wait RD_LAT cycles (SRC_WT).
  - If the code is empty or of the opposite colour, go to FIN with err=1.
  - Otherwise set dir=N and cur=src, and go to STEP.
- Direction order: N(+8), S(-8), E(+1), W(-1).
- STEP: compute the next square from cur.
  - Off-board cases: N at rank 7, S at rank 0, E at file 7, W at file 0.
  - Off-board goes to NXT_DIR. File wrap (h->a) is never produced.
  - On board: cur=next, go to RD.
- RD: ram_en=1 for exactly one cycle, ram_addr=cur. WT covers the remaining RD_LAT-1 cycles. CHK samples ram_rdata.
- CHK outcomes:
  - Empty: EMIT with capture=0, then return to STEP.
  - Enemy: EMIT with capture=1, then NXT_DIR.
  - Own: NXT_DIR with no emit.
- EMIT: mv_valid=1.
  - mv_dst and mv_capture stay stable until the transfer completes.
  - move_count increments on the transfer.
  - mv_valid never drops without a transfer, except on reset.
- NXT_DIR: advance dir and reset cur=src. After W, go to FIN.
- FIN: done=1 for one cycle, busy drops in the same cycle, return to IDLE.
- Throughput with RD_LAT=1 and mv_ready held high: 4 cycles per emitted empty square (STEP, RD, CHK, EMIT).
- move_count clears to 0 when start is accepted.
- ram_en is never asserted outside SRC_RD/RD; the block never writes RAM.
- start while busy: ignored, no effect on the latched operands.
- Reset mid-scan: immediate return to IDLE on the next edge, all outputs at reset values, no done pulse.
- Board contents are assumed static during a scan; the arbiter guarantees no RAM writes while busy=1.

Decomposition:
- Package chess_pkg holds:
  - piece code constants (EMPTY=0, WHITE_MAX=16).
  - function is_white/is_black(code).
  - typedef dir_t {N,S,E,W}.
  - typedef scan_state_t.
  - SQ_W/PC_W localparams shared with the board RAM.
- Sub-module sq_step (combinational): inputs sq and dir; outputs next_sq and off_board. It is reused later by the bishop/queen scanners with diagonal dir values.

Test Plan:
- Initial board, src=0 (a1 rook, code 13), side=0 -> zero mv_valid, done with move_count=0, err=0.
- Empty board except a white rook at 27 (d4), mv_ready=1 -> 14 moves in order 35,43,51,59,19,11,3,28,29,30,31,26,25,24, all capture=0, move_count=14.
- White rook at 27, black pawn (17) at 43, white pawn (1) at 28 -> moves 35, 43(capture=1), 19, 11, 3, 26, 25, 24; move_count=8.
- Scan as in the second scenario with mv_ready low for 5 cycles at the first emit -> mv_valid and mv_dst=35 held stable all 5 cycles, no RAM read issued meanwhile, and no duplicate emits.
- src=20 (empty) -> done and err pulse together in the same cycle, move_count=0.
- Second scenario with reset asserted after the 3rd transfer -> next cycle busy=0, mv_valid=0, ram_en=0, move_count=0, no done. A following start runs a full 14-move scan.
- Repeat the second and third scenarios with RD_LAT=2 -> same move sequences.

Source files
------------

// File: rtl/chess_pkg.sv
// Shared chess encodings: square/piece widths, piece colour helpers, ray directions
// and the rook scanner state type.
package chess_pkg;

  localparam int unsigned SQ_W   = 6;
  localparam int unsigned PC_W   = 5;
  localparam int unsigned RANK_W = 3;

  localparam logic [PC_W-1:0] EMPTY     = PC_W'(0);
  localparam logic [PC_W-1:0] WHITE_MAX = PC_W'(16);

  // Orthogonal rays first; diagonals are for the bishop/queen scanners.
  typedef enum logic [2:0] {
    DIR_N, DIR_S, DIR_E, DIR_W, DIR_NE, DIR_NW, DIR_SE, DIR_SW
  } dir_t;

  typedef enum logic [3:0] {
    IDLE, SRC_RD, SRC_WT, STEP, RD, WT, CHK, EMIT, NXT_DIR, FIN
  } scan_state_t;

  function automatic logic is_white(input logic [PC_W-1:0] code);
    return (code != EMPTY) && (code <= WHITE_MAX);
  endfunction

  function automatic logic is_black(input logic [PC_W-1:0] code);
    return code > WHITE_MAX;
  endfunction

endpackage

// File: rtl/sq_step.sv
// One-square step along a ray; flags moves that would leave the board instead of
// wrapping across a file or rank edge.
module sq_step
  import chess_pkg::*;
(
  input  logic [SQ_W-1:0] sq,
  input  dir_t            dir,
  output logic [SQ_W-1:0] next_sq,
  output logic            off_board
);

  logic [RANK_W-1:0] rank;
  logic [RANK_W-1:0] file;
  logic [RANK_W-1:0] next_rank;
  logic [RANK_W-1:0] next_file;
  logic              up;
  logic              dn;
  logic              rt;
  logic              lf;

  always_comb begin
    rank = sq[SQ_W-1 -: RANK_W];
    file = sq[RANK_W-1:0];
    up   = 1'b0;
    dn   = 1'b0;
    rt   = 1'b0;
    lf   = 1'b0;
    case (dir)
      DIR_N:   up = 1'b1;
      DIR_S:   dn = 1'b1;
      DIR_E:   rt = 1'b1;
      DIR_W:   lf = 1'b1;
      DIR_NE:  begin up = 1'b1; rt = 1'b1; end
      DIR_NW:  begin up = 1'b1; lf = 1'b1; end
      DIR_SE:  begin dn = 1'b1; rt = 1'b1; end
      DIR_SW:  begin dn = 1'b1; lf = 1'b1; end
      default: up = 1'b0;
    endcase

    off_board = (up && (rank == RANK_W'(7))) || (dn && (rank == RANK_W'(0))) ||
                (rt && (file == RANK_W'(7))) || (lf && (file == RANK_W'(0)));

    next_rank = up ? rank + RANK_W'(1) : (dn ? rank - RANK_W'(1) : rank);
    next_file = rt ? file + RANK_W'(1) : (lf ? file - RANK_W'(1) : file);
    next_sq   = {next_rank, next_file};
  end

endmodule

// File: rtl/rook_move_scanner.sv
// Walks the four orthogonal rays from a source square through the board RAM read
// port and streams each pseudo-legal destination to the move checker.
module rook_move_scanner
  import chess_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [SQ_W-1:0] src_sq,
  input  logic            side,
  output logic            busy,
  output logic            ram_en,
  output logic [SQ_W-1:0] ram_addr,
  input  logic [PC_W-1:0] ram_rdata,
  output logic            mv_valid,
  input  logic            mv_ready,
  output logic [SQ_W-1:0] mv_dst,
  output logic            mv_capture,
  output logic            done,
  output logic            err,
  output logic [3:0]      move_count
);

  localparam int unsigned WAIT_W = 2;
  localparam int unsigned CNT_W  = 4;

  scan_state_t       state, state_d;
  logic [SQ_W-1:0]   src_q, src_d;
  logic              side_q, side_d;
  dir_t              dir_q, dir_d;
  logic [SQ_W-1:0]   cur_q, cur_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [SQ_W-1:0]   ram_addr_d;
  logic [SQ_W-1:0]   mv_dst_d;
  logic              mv_cap_d;
  logic              err_d;
  logic [CNT_W-1:0]  cnt_d;
  logic [SQ_W-1:0]   step_next;
  logic              step_off;
  logic              own_pc;
  logic              empty_pc;

  sq_step u_step (
    .sq        (cur_q),
    .dir       (dir_q),
    .next_sq   (step_next),
    .off_board (step_off)
  );

  always_comb begin
    empty_pc = (ram_rdata == EMPTY);
    own_pc   = side_q ? is_black(ram_rdata) : is_white(ram_rdata);
  end

  // Next-state and next-output logic; outputs are registered from these values.
  always_comb begin
    state_d    = state;
    src_d      = src_q;
    side_d     = side_q;
    dir_d      = dir_q;
    cur_d      = cur_q;
    wait_d     = wait_q;
    ram_addr_d = ram_addr;
    mv_dst_d   = mv_dst;
    mv_cap_d   = mv_capture;
    err_d      = 1'b0;
    cnt_d      = move_count;

    case (state)
      IDLE: begin
        if (start) begin
          src_d      = src_sq;
          side_d     = side;
          cnt_d      = CNT_W'(0);
          ram_addr_d = src_sq;
          state_d    = SRC_RD;
        end
      end
      SRC_RD: begin
        wait_d  = WAIT_W'(RD_LAT - 1);
        state_d = SRC_WT;
      end
      SRC_WT: begin
        if (wait_q != WAIT_W'(0)) begin
          wait_d = wait_q - WAIT_W'(1);
        end else if (own_pc) begin
          dir_d   = DIR_N;
          cur_d   = src_q;
          state_d = STEP;
        end else begin
          err_d   = 1'b1;
          state_d = FIN;
        end
      end
      STEP: begin
        if (step_off) begin
          state_d = NXT_DIR;
        end else begin
          cur_d      = step_next;
          ram_addr_d = step_next;
          state_d    = RD;
        end
      end
      RD: begin
        if (RD_LAT > 1) begin
          wait_d  = WAIT_W'((RD_LAT > 1) ? RD_LAT - 2 : 0);
          state_d = WT;
        end else begin
          state_d = CHK;
        end
      end
      WT: begin
        if (wait_q != WAIT_W'(0)) begin
          wait_d = wait_q - WAIT_W'(1);
        end else begin
          state_d = CHK;
        end
      end
      CHK: begin
        if (empty_pc) begin
          mv_dst_d = cur_q;
          mv_cap_d = 1'b0;
          state_d  = EMIT;
        end else if (own_pc) begin
          state_d = NXT_DIR;
        end else begin
          mv_dst_d = cur_q;
          mv_cap_d = 1'b1;
          state_d  = EMIT;
        end
      end
      EMIT: begin
        // A capture ends the ray; a quiet move continues along it.
        if (mv_ready) begin
          cnt_d   = move_count + CNT_W'(1);
          state_d = mv_capture ? NXT_DIR : STEP;
        end
      end
      NXT_DIR: begin
        if (dir_q == DIR_W) begin
          state_d = FIN;
        end else begin
          dir_d   = dir_t'(3'(dir_q) + 3'd1);
          cur_d   = src_q;
          state_d = STEP;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      src_q      <= '0;
      side_q     <= 1'b0;
      dir_q      <= DIR_N;
      cur_q      <= '0;
      wait_q     <= '0;
      busy       <= 1'b0;
      ram_en     <= 1'b0;
      ram_addr   <= '0;
      mv_valid   <= 1'b0;
      mv_dst     <= '0;
      mv_capture <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      move_count <= '0;
    end else begin
      state      <= state_d;
      src_q      <= src_d;
      side_q     <= side_d;
      dir_q      <= dir_d;
      cur_q      <= cur_d;
      wait_q     <= wait_d;
      busy       <= (state_d != IDLE) && (state_d != FIN);
      ram_en     <= (state_d == SRC_RD) || (state_d == RD);
      ram_addr   <= ram_addr_d;
      mv_valid   <= (state_d == EMIT);
      mv_dst     <= mv_dst_d;
      mv_capture <= mv_cap_d;
      done       <= (state_d == FIN);
      err        <= err_d;
      move_count <= cnt_d;
    end
  end

endmodule

// File: tb/tb_rook_move_scanner.sv
// Bench for rook_move_scanner: two instances (read latency 1 and 2) share a board
// model; results are checked against a ray-walking reference built from rank/file math.
module tb_rook_move_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [5:0] src_sq;
  logic       side;
  logic       mv_ready;
  logic       lat2;

  always #5 clk = ~clk;

  logic       busy1, ram_en1, mv_valid1, mv_cap1, done1, err1;
  logic [5:0] ram_addr1, mv_dst1;
  logic [4:0] rdata1;
  logic [3:0] cnt1;
  logic       busy2, ram_en2, mv_valid2, mv_cap2, done2, err2;
  logic [5:0] ram_addr2, mv_dst2;
  logic [4:0] rdata2;
  logic [3:0] cnt2;

  rook_move_scanner #(.RD_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .src_sq(src_sq), .side(side),
    .busy(busy1), .ram_en(ram_en1), .ram_addr(ram_addr1), .ram_rdata(rdata1),
    .mv_valid(mv_valid1), .mv_ready(mv_ready), .mv_dst(mv_dst1),
    .mv_capture(mv_cap1), .done(done1), .err(err1), .move_count(cnt1)
  );

  rook_move_scanner #(.RD_LAT(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .src_sq(src_sq), .side(side),
    .busy(busy2), .ram_en(ram_en2), .ram_addr(ram_addr2), .ram_rdata(rdata2),
    .mv_valid(mv_valid2), .mv_ready(mv_ready), .mv_dst(mv_dst2),
    .mv_capture(mv_cap2), .done(done2), .err(err2), .move_count(cnt2)
  );

  // Board RAM model with one read pipeline per latency.
  logic [4:0] board [64];
  logic [4:0] d1a, d1b, d2b;
  always @(posedge clk) begin
    if (ram_en1) d1a <= board[ram_addr1];
    if (ram_en2) d1b <= board[ram_addr2];
    d2b <= d1b;
  end
  assign rdata1 = d1a;
  assign rdata2 = d2b;

  logic       busy, ram_en, mv_valid, mv_capture, done, err;
  logic [5:0] mv_dst;
  logic [3:0] move_count;
  always_comb begin
    busy       = lat2 ? busy2     : busy1;
    ram_en     = lat2 ? ram_en2   : ram_en1;
    mv_valid   = lat2 ? mv_valid2 : mv_valid1;
    mv_capture = lat2 ? mv_cap2   : mv_cap1;
    done       = lat2 ? done2     : done1;
    err        = lat2 ? err2      : err1;
    mv_dst     = lat2 ? mv_dst2   : mv_dst1;
    move_count = lat2 ? cnt2      : cnt1;
  end

  int vectors = 0;
  int miscompares = 0;

  logic [5:0] got_dst[$];
  logic       got_cap[$];
  logic       got_done, got_err, stray_err;
  int         exp_dst[$];
  int         exp_cap[$];
  bit         exp_err;

  task automatic clear_board();
    for (int i = 0; i < 64; i++) board[i] = 5'd0;
  endtask

  task automatic init_board();
    int wp[8];
    int bp[8];
    wp = '{13, 11, 9, 15, 16, 10, 12, 14};
    bp = '{29, 27, 25, 31, 30, 26, 28, 29};
    clear_board();
    for (int f = 0; f < 8; f++) begin
      board[f]      = 5'(wp[f]);
      board[8 + f]  = 5'(f + 1);
      board[48 + f] = 5'(17 + f);
      board[56 + f] = 5'(bp[f]);
    end
  endtask

  // Reference: walk each ray in N,S,E,W order using rank/file coordinates.
  task automatic ref_scan(input int src, input logic sd);
    int dr[4];
    int df[4];
    int r, f;
    logic [4:0] c, pc;
    dr = '{1, -1, 0, 0};
    df = '{0, 0, 1, -1};
    exp_dst.delete();
    exp_cap.delete();
    pc = board[src];
    exp_err = (pc == 5'd0) || (sd ? (pc <= 5'd16) : (pc > 5'd16));
    if (!exp_err) begin
      for (int d = 0; d < 4; d++) begin
        r = src / 8 + dr[d];
        f = src % 8 + df[d];
        while (r >= 0 && r < 8 && f >= 0 && f < 8) begin
          c = board[r * 8 + f];
          if (c == 5'd0) begin
            exp_dst.push_back(r * 8 + f);
            exp_cap.push_back(0);
          end else begin
            if ((c > 5'd16) != sd) begin
              exp_dst.push_back(r * 8 + f);
              exp_cap.push_back(1);
            end
            break;
          end
          r += dr[d];
          f += df[d];
        end
      end
    end
  endtask

  function automatic int first_diff();
    int n;
    n = (got_dst.size() < exp_dst.size()) ? got_dst.size() : exp_dst.size();
    for (int i = 0; i < n; i++)
      if (got_dst[i] !== 6'(exp_dst[i]) || got_cap[i] !== 1'(exp_cap[i])) return i;
    if (got_dst.size() != exp_dst.size()) return n;
    return -1;
  endfunction

  // rmode: 0 ready high, 1 random ready plus stray starts, 2 ready low 5 cycles at first emit.
  task automatic do_scan(input int src, input logic sd, input int rmode, input int rst_after);
    logic       pv, pcap, fin, rst_now;
    logic [5:0] pdst;
    int         stall, xfers;
    got_dst.delete();
    got_cap.delete();
    got_done = 1'b0; got_err = 1'b0; stray_err = 1'b0;
    @(negedge clk);
    reset = 1'b1; start = 1'b0; mv_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0; start = 1'b1; src_sq = 6'(src); side = sd;
    @(negedge clk);
    start = 1'b0; src_sq = 6'($urandom); side = 1'($urandom);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_after_start: got %b want 1", busy);
    end
    pv = 1'b0; pcap = 1'b0; pdst = '0; stall = 0; xfers = 0; fin = 1'b0; rst_now = 1'b0;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      if (rst_now) begin
        reset = 1'b1; mv_ready = 1'b0; start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if ({busy, mv_valid, ram_en, done, move_count} !== 8'b0) begin
          miscompares++;
          $display("FAIL reset_mid_scan: busy=%b valid=%b ram_en=%b done=%b count=%0d want all 0",
                   busy, mv_valid, ram_en, done, move_count);
        end
        return;
      end
      if (pv) begin
        vectors++;
        if (mv_valid !== 1'b1 || mv_dst !== pdst || mv_capture !== pcap) begin
          miscompares++;
          $display("FAIL stall_hold: valid=%b dst=%0d cap=%b want 1/%0d/%b",
                   mv_valid, mv_dst, mv_capture, pdst, pcap);
        end
      end
      vectors++;
      if (mv_valid === 1'b1 && ram_en !== 1'b0) begin
        miscompares++;
        $display("FAIL ram_en_during_emit: ram_en=%b want 0", ram_en);
      end
      if (err === 1'b1 && done !== 1'b1) stray_err = 1'b1;
      if (done === 1'b1) begin
        got_done = 1'b1;
        got_err  = err;
        fin      = 1'b1;
        vectors++;
        if (busy !== 1'b0) begin
          miscompares++;
          $display("FAIL busy_at_done: got %b want 0", busy);
        end
      end else begin
        case (rmode)
          1: begin
            mv_ready = ($urandom_range(0, 2) != 0);
            start    = ($urandom_range(0, 7) == 0);
            src_sq   = 6'($urandom);
            side     = 1'($urandom);
          end
          2: begin
            if (mv_valid === 1'b1 && got_dst.size() == 0 && stall < 5) begin
              mv_ready = 1'b0;
              stall++;
            end else begin
              mv_ready = 1'b1;
            end
          end
          default: mv_ready = 1'b1;
        endcase
        if (mv_valid === 1'b1 && mv_ready) begin
          got_dst.push_back(mv_dst);
          got_cap.push_back(mv_capture);
          xfers++;
          pv = 1'b0;
          if (rst_after != 0 && xfers == rst_after) rst_now = 1'b1;
        end else begin
          pv   = mv_valid;
          pdst = mv_dst;
          pcap = mv_capture;
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    mv_ready = 1'b0;
    if (!fin) begin
      vectors++;
      miscompares++;
      $display("FAIL scan_timeout: no done within cycle budget");
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mv_ready = 1'b0; src_sq = '0; side = 1'b0; lat2 = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy1, ram_en1, mv_valid1, mv_cap1, done1, err1, ram_addr1, mv_dst1, cnt1,
         busy2, ram_en2, mv_valid2, mv_cap2, done2, err2, ram_addr2, mv_dst2, cnt2} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: dut1 busy=%b en=%b v=%b d=%b e=%b addr=%0d dst=%0d cnt=%0d; dut2 busy=%b cnt=%0d want all 0",
               busy1, ram_en1, mv_valid1, done1, err1, ram_addr1, mv_dst1, cnt1, busy2, cnt2);
    end
    reset = 1'b0;
  endtask

  task automatic test_initial_board();
    int idx;
    init_board();
    lat2 = 1'b0;
    do_scan(0, 1'b0, 0, 0);
    vectors++;
    if (got_done !== 1'b1 || got_err !== 1'b0) begin
      miscompares++;
      $display("FAIL init_done_err: done=%b err=%b want 1/0", got_done, got_err);
    end
    exp_dst.delete(); exp_cap.delete();
    idx = first_diff();
    vectors++;
    if (idx >= 0 || move_count !== 4'd0) begin
      miscompares++;
      $display("FAIL init_moves: got %0d moves count=%0d want 0/0", got_dst.size(), move_count);
    end
  endtask

  // Open board and blocked board, at both read latencies, against fixed move lists.
  task automatic test_open_and_blocked();
    int idx;
    for (int l = 0; l < 2; l++) begin
      for (int sc = 0; sc < 2; sc++) begin
        lat2 = 1'(l);
        clear_board();
        board[27] = 5'd13;
        if (sc == 0) begin
          exp_dst = '{35, 43, 51, 59, 19, 11, 3, 28, 29, 30, 31, 26, 25, 24};
          exp_cap = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        end else begin
          board[43] = 5'd17;
          board[28] = 5'd1;
          exp_dst = '{35, 43, 19, 11, 3, 26, 25, 24};
          exp_cap = '{0, 1, 0, 0, 0, 0, 0, 0};
        end
        do_scan(27, 1'b0, 0, 0);
        vectors++;
        if (got_done !== 1'b1 || got_err !== 1'b0) begin
          miscompares++;
          $display("FAIL scan%0d_lat%0d_done: done=%b err=%b want 1/0", sc, l + 1, got_done, got_err);
        end
        idx = first_diff();
        vectors++;
        if (idx >= 0) begin
          miscompares++;
          $display("FAIL scan%0d_lat%0d_moves: got %0d moves want %0d, first diff at %0d",
                   sc, l + 1, got_dst.size(), exp_dst.size(), idx);
        end
        vectors++;
        if (move_count !== 4'(exp_dst.size())) begin
          miscompares++;
          $display("FAIL scan%0d_lat%0d_count: got %0d want %0d", sc, l + 1, move_count, exp_dst.size());
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int idx;
    clear_board();
    board[27] = 5'd13;
    lat2 = 1'b0;
    exp_dst = '{35, 43, 51, 59, 19, 11, 3, 28, 29, 30, 31, 26, 25, 24};
    exp_cap = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    do_scan(27, 1'b0, 2, 0);
    idx = first_diff();
    vectors++;
    if (idx >= 0 || move_count !== 4'd14) begin
      miscompares++;
      $display("FAIL backpressure_moves: got %0d moves count=%0d want 14/14, first diff at %0d",
               got_dst.size(), move_count, idx);
    end
  endtask

  task automatic test_empty_src();
    init_board();
    lat2 = 1'b0;
    do_scan(20, 1'b0, 0, 0);
    vectors++;
    if (got_done !== 1'b1 || got_err !== 1'b1 || stray_err !== 1'b0) begin
      miscompares++;
      $display("FAIL empty_src_err: done=%b err_with_done=%b stray_err=%b want 1/1/0",
               got_done, got_err, stray_err);
    end
    vectors++;
    if (move_count !== 4'd0 || got_dst.size() != 0) begin
      miscompares++;
      $display("FAIL empty_src_count: count=%0d moves=%0d want 0/0", move_count, got_dst.size());
    end
  endtask

  task automatic test_reset_mid_scan();
    int idx;
    clear_board();
    board[27] = 5'd13;
    lat2 = 1'b0;
    do_scan(27, 1'b0, 0, 3);
    vectors++;
    if (got_dst.size() != 3 || got_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_xfers: moves=%0d done=%b want 3/0", got_dst.size(), got_done);
    end
    exp_dst = '{35, 43, 51, 59, 19, 11, 3, 28, 29, 30, 31, 26, 25, 24};
    exp_cap = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    do_scan(27, 1'b0, 0, 0);
    idx = first_diff();
    vectors++;
    if (idx >= 0 || move_count !== 4'd14 || got_done !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_then_rescan: moves=%0d count=%0d done=%b want 14/14/1",
               got_dst.size(), move_count, got_done);
    end
  endtask

  task automatic test_random();
    int   src, idx;
    logic sd;
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < 64; i++)
        board[i] = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      src  = $urandom_range(0, 63);
      sd   = 1'($urandom);
      lat2 = 1'($urandom);
      if ($urandom_range(0, 3) != 0) board[src] = sd ? 5'($urandom_range(17, 31)) : 5'($urandom_range(1, 16));
      ref_scan(src, sd);
      do_scan(src, sd, 1, 0);
      vectors++;
      if (got_done !== 1'b1 || got_err !== exp_err || stray_err !== 1'b0) begin
        miscompares++;
        $display("FAIL rand%0d_status: src=%0d side=%b done=%b err=%b stray=%b want 1/%b/0",
                 it, src, sd, got_done, got_err, stray_err, exp_err);
      end
      idx = first_diff();
      vectors++;
      if (idx >= 0 || move_count !== 4'(exp_dst.size())) begin
        miscompares++;
        $display("FAIL rand%0d_moves: src=%0d side=%b lat=%0d got %0d moves count=%0d want %0d, first diff at %0d",
                 it, src, sd, lat2 + 1, got_dst.size(), move_count, exp_dst.size(), idx);
      end
    end
  endtask

  initial begin
    test_reset();
    test_initial_board();
    test_open_and_blocked();
    test_backpressure();
    test_empty_src();
    test_reset_mid_scan();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
